// File: rtl/card_frame_encoder.sv
// Queues START/DEAL/FIN game events per player and streams them as checksummed byte frames into the uart TX FIFO.
// Latency: request in cycle N -> SOF written in N+2; back-pressure via tx_full holds the current byte and state.
module card_frame_encoder #(
    parameter int          NUM_PLAYERS    = 2,
    parameter int          CARDS_PER_HAND = 8,
    parameter int          CARD_W         = 4,
    parameter logic [7:0]  SOF            = 8'hA5,
    localparam int         PID_W          = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int         CNT_W          = $clog2(CARDS_PER_HAND + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_req,
    input  logic                             deal_req,
    input  logic                             fin_req,
    input  logic [PID_W-1:0]                 player_id,
    input  logic [CARDS_PER_HAND*CARD_W-1:0] hand_cards,
    input  logic [CNT_W-1:0]                 hand_count,
    input  logic                             tx_full,
    output logic                             wr_uart,
    output logic [7:0]                       w_data,
    output logic                             busy,
    output logic                             dropped
);

    typedef enum logic [2:0] {S_IDLE, S_SOF, S_HDR, S_LEN, S_PAY, S_CHK} state_t;

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(CARDS_PER_HAND);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t                            state, state_nxt;
    logic [2:0]                        flags;   // bit0 START, bit1 DEAL, bit2 FIN
    logic [PID_W-1:0]                  ids [3];
    logic [3:0]                        cur_type;
    logic [PID_W-1:0]                  cur_id;
    logic [CNT_W-1:0]                  cur_len;
    logic [CNT_W-1:0]                  idx;
    logic [CARDS_PER_HAND*CARD_W-1:0]  hand_q;
    logic [7:0]                        chk;
    logic [2:0]                        req, grant, accept;
    logic                              wr;

    assign req     = {fin_req, deal_req, start_req};
    // A flag being cleared by the grant on this edge can take a new request.
    assign accept  = req & (~flags | grant);
    assign wr_uart = wr & ~rst;
    assign busy    = (state != S_IDLE) || (|flags);

    always_comb begin
        state_nxt = state;
        wr        = 1'b0;
        w_data    = 8'h00;
        grant     = 3'b000;
        case (state)
            S_IDLE: begin
                if (flags[0])      grant = 3'b001;
                else if (flags[1]) grant = 3'b010;
                else if (flags[2]) grant = 3'b100;
                if (|flags) state_nxt = S_SOF;
            end
            S_SOF: begin
                w_data = SOF;
                wr     = ~tx_full;
                if (wr) state_nxt = S_HDR;
            end
            S_HDR: begin
                w_data = {cur_type, 4'(cur_id)};
                wr     = ~tx_full;
                if (wr) state_nxt = S_LEN;
            end
            S_LEN: begin
                w_data = 8'(cur_len);
                wr     = ~tx_full;
                if (wr) state_nxt = (cur_len != '0) ? S_PAY : S_CHK;
            end
            S_PAY: begin
                w_data = 8'(hand_q[int'(idx)*CARD_W +: CARD_W]);
                wr     = ~tx_full;
                if (wr && idx == cur_len - ONE) state_nxt = S_CHK;
            end
            S_CHK: begin
                w_data = chk;
                wr     = ~tx_full;
                if (wr) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            flags    <= 3'b000;
            for (int i = 0; i < 3; i++) ids[i] <= '0;
            cur_type <= 4'h0;
            cur_id   <= '0;
            cur_len  <= '0;
            idx      <= '0;
            hand_q   <= '0;
            chk      <= 8'h00;
            dropped  <= 1'b0;
        end else begin
            state   <= state_nxt;
            flags   <= req | (flags & ~grant);
            dropped <= |(req & flags & ~grant);
            for (int i = 0; i < 3; i++) begin
                if (accept[i]) ids[i] <= player_id;
            end
            if (|grant) begin
                cur_type <= grant[0] ? 4'h1 : (grant[1] ? 4'h2 : 4'h3);
                cur_id   <= grant[0] ? ids[0] : (grant[1] ? ids[1] : ids[2]);
                cur_len  <= grant[1] ? ((hand_count > MAX_LEN) ? MAX_LEN : hand_count) : '0;
                hand_q   <= hand_cards;
                idx      <= '0;
                chk      <= 8'h00;
            end
            if (wr) begin
                if (state == S_HDR || state == S_LEN || state == S_PAY) chk <= chk ^ w_data;
                if (state == S_PAY) idx <= idx + ONE;
            end
        end
    end

endmodule

// File: tb/tb_card_frame_encoder.sv
// Scoreboarded bench for card_frame_encoder: expected frames are built from the frame rules and checked byte by byte.
module tb_card_frame_encoder;

    localparam int CPH = 8;
    localparam int CW  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_req = 1'b0, deal_req = 1'b0, fin_req = 1'b0;
    logic [0:0]  player_id = 1'b0;
    logic [31:0] hand_cards = 32'h0;
    logic [3:0]  hand_count = 4'h0;
    logic        tx_full = 1'b0;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        busy, dropped;

    card_frame_encoder #(.NUM_PLAYERS(2), .CARDS_PER_HAND(CPH), .CARD_W(CW), .SOF(8'hA5)) dut (
        .clk(clk), .rst(rst), .start_req(start_req), .deal_req(deal_req), .fin_req(fin_req),
        .player_id(player_id), .hand_cards(hand_cards), .hand_count(hand_count), .tx_full(tx_full),
        .wr_uart(wr_uart), .w_data(w_data), .busy(busy), .dropped(dropped)
    );

    always #5 clk = ~clk;

    int          checks = 0, failures = 0;
    int          cyc = 0, nbytes = 0, drop_cnt = 0;
    bit          rand_full = 1'b0;
    logic [7:0]  exp_q[$];
    int          wr_cycles[$];
    logic [7:0]  mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_full) begin
            #1;
            tx_full = ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor: every written byte is compared against the head of the expectation queue.
    always @(negedge clk) begin
        if (dropped) drop_cnt++;
        if (wr_uart) begin
            nbytes++;
            wr_cycles.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_byte actual=%02h required=no write", w_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (w_data !== mon_exp) begin
                    failures++;
                    $display("FAIL frame_byte actual=%02h required=%02h", w_data, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_frame(input int t, input int pid, input logic [31:0] hand, input int cnt);
        int len, hdr, ck, b;
        len = (t == 2) ? ((cnt > CPH) ? CPH : cnt) : 0;
        hdr = t * 16 + pid;
        ck  = hdr ^ len;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(hdr));
        exp_q.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            b = int'((hand >> (CW * i)) & 32'hF);
            exp_q.push_back(8'(b));
            ck = ck ^ b;
        end
        exp_q.push_back(8'(ck));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit s, input bit d, input bit f, input int pid);
        start_req = s;
        deal_req  = d;
        fin_req   = f;
        player_id = 1'(pid);
        step();
        start_req = 1'b0;
        deal_req  = 1'b0;
        fin_req   = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < maxc) begin
            step();
            n++;
        end
        check("idle_within_budget", int'(n < maxc), 1);
    endtask

    task automatic wait_bytes(input int target);
        int n = 0;
        while (nbytes != target && n < 40) begin
            step();
            n++;
        end
        check("byte_count_reached", nbytes, target);
    endtask

    initial begin
        int n0, base, bad, cnt, pid, mask;
        logic [31:0] h;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        check("rst_wr_uart", int'(wr_uart), 0);
        check("rst_w_data", int'(w_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_dropped", int'(dropped), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // DEAL player 1, cards {10,7}: A5 21 02 0A 07 2E, first byte at N+2
        hand_cards = 32'h0000_007A;
        hand_count = 4'd2;
        wr_cycles.delete();
        n0 = cyc;
        push_frame(2, 1, hand_cards, 2);
        pulse(0, 1, 0, 1);
        wait_idle(50);
        check("deal_byte_count", wr_cycles.size(), 6);
        if (wr_cycles.size() >= 6) begin
            check("deal_first_write_cycle", wr_cycles[0], n0 + 2);
            check("deal_last_write_cycle", wr_cycles[5], n0 + 7);
        end

        // START player 0, FIN player 1
        push_frame(1, 0, hand_cards, 2);
        pulse(1, 0, 0, 0);
        wait_idle(50);
        push_frame(3, 1, hand_cards, 2);
        pulse(0, 0, 1, 1);
        wait_idle(50);

        // START and DEAL together: START frame, one idle cycle, DEAL frame; busy throughout
        hand_cards = 32'h0000_0035;
        wr_cycles.delete();
        n0 = cyc;
        push_frame(1, 1, hand_cards, 2);
        push_frame(2, 1, hand_cards, 2);
        pulse(1, 1, 0, 1);
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (!busy) bad++;
            step();
        end
        @(negedge clk);
        check("busy_during_frames", bad, 0);
        check("busy_after_chk", int'(busy), 0);
        check("pair_byte_count", wr_cycles.size(), 10);
        if (wr_cycles.size() >= 10) begin
            check("start_chk_cycle", wr_cycles[3], n0 + 5);
            check("deal_sof_cycle", wr_cycles[4], n0 + 7);
        end
        step();
        wait_idle(50);

        // Back-pressure during HDR; hand changes mid-frame are ignored
        hand_cards = 32'h0000_0C94;
        hand_count = 4'd3;
        push_frame(2, 0, hand_cards, 3);
        base = nbytes;
        pulse(0, 1, 0, 0);
        wait_bytes(base + 1);
        tx_full    = 1'b1;
        hand_cards = $urandom;
        hand_count = 4'd7;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_wr_uart", int'(wr_uart), 0);
            check("stall_w_data_hdr", int'(w_data), 8'h20);
            step();
        end
        tx_full = 1'b0;
        wait_idle(50);

        // Second DEAL while DEAL pending is dropped; hand_count 12 clamps to LEN 8
        hand_cards = $urandom;
        hand_count = 4'd12;
        drop_cnt   = 0;
        push_frame(1, 1, hand_cards, 12);
        push_frame(2, 1, hand_cards, 12);
        pulse(1, 1, 0, 1);
        step();
        step();
        pulse(0, 1, 0, 0);
        wait_idle(100);
        check("dropped_pulses", drop_cnt, 1);

        // Reset during PAY aborts the frame and clears the pending FIN
        hand_cards = $urandom;
        hand_count = 4'd5;
        push_frame(2, 0, hand_cards, 5);
        base = nbytes;
        pulse(0, 1, 1, 0);
        wait_bytes(base + 5);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("wr_uart_in_reset", int'(wr_uart), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) step();
        check("busy_after_reset", int'(busy), 0);
        check("no_bytes_after_reset", nbytes, base + 5);

        // Randomized request mixes under random back-pressure
        rand_full = 1'b1;
        for (int it = 0; it < 40; it++) begin
            h    = $urandom;
            cnt  = $urandom_range(0, 15);
            pid  = $urandom_range(0, 1);
            mask = $urandom_range(1, 7);
            hand_cards = h;
            hand_count = 4'(cnt);
            if (mask[0]) push_frame(1, pid, h, cnt);
            if (mask[1]) push_frame(2, pid, h, cnt);
            if (mask[2]) push_frame(3, pid, h, cnt);
            pulse(mask[0], mask[1], mask[2], pid);
            wait_idle(3000);
        end
        rand_full = 1'b0;
        step();
        tx_full = 1'b0;
        repeat (5) step();
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
